mul20_compressor: RTL and testbench

//   Partial-product compressor for a 20x20 unsigned array multiplier.
//   - Takes the 39 bit-columns of the partial-product matrix.
//   - Reduces them through a cascade of 3:2 / 2:2 counters plus a final carry-propagate add.
//   - Registers the 40-bit product, one bit per output port.
//   - Sits between the partial-product generator (or input shift register) and the product consumer.

---
 rtl/mul20_compressor.sv | 217 +++++++++++++++++++++
 tb/tb_mul20_compressor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mul20_compressor.sv
// Purpose : 20x20 unsigned partial-product compressor (3:2 carry-save tree + final add).
// Latency : 1 cycle, from src columns to the dst register.
// Backpressure: none; accepts one operand set per cycle and never stalls.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   srcI         bit-column I of the partial-product matrix (weight 2^I);
//                width I+1 for I<20, width 39-I for I>=20
//   dstK         bit K of the registered 40-bit product
module mul20_compressor #(
  parameter int N = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:0]  src0,
  input  logic [1:0]  src1,
  input  logic [2:0]  src2,
  input  logic [3:0]  src3,
  input  logic [4:0]  src4,
  input  logic [5:0]  src5,
  input  logic [6:0]  src6,
  input  logic [7:0]  src7,
  input  logic [8:0]  src8,
  input  logic [9:0]  src9,
  input  logic [10:0] src10,
  input  logic [11:0] src11,
  input  logic [12:0] src12,
  input  logic [13:0] src13,
  input  logic [14:0] src14,
  input  logic [15:0] src15,
  input  logic [16:0] src16,
  input  logic [17:0] src17,
  input  logic [18:0] src18,
  input  logic [19:0] src19,
  input  logic [18:0] src20,
  input  logic [17:0] src21,
  input  logic [16:0] src22,
  input  logic [15:0] src23,
  input  logic [14:0] src24,
  input  logic [13:0] src25,
  input  logic [12:0] src26,
  input  logic [11:0] src27,
  input  logic [10:0] src28,
  input  logic [9:0]  src29,
  input  logic [8:0]  src30,
  input  logic [7:0]  src31,
  input  logic [6:0]  src32,
  input  logic [5:0]  src33,
  input  logic [4:0]  src34,
  input  logic [3:0]  src35,
  input  logic [2:0]  src36,
  input  logic [1:0]  src37,
  input  logic [0:0]  src38,
  output logic        dst0,  dst1,  dst2,  dst3,  dst4,  dst5,  dst6,  dst7,
  output logic        dst8,  dst9,  dst10, dst11, dst12, dst13, dst14, dst15,
  output logic        dst16, dst17, dst18, dst19, dst20, dst21, dst22, dst23,
  output logic        dst24, dst25, dst26, dst27, dst28, dst29, dst30, dst31,
  output logic        dst32, dst33, dst34, dst35, dst36, dst37, dst38, dst39
);

  localparam int W    = 2 * N;      // product width
  localparam int NCOL = 2 * N - 1;  // number of input columns

  // Number of carry-save rows left after s levels of 3:2 compression.
  // Each group of three rows becomes two; leftover rows pass through.
  function automatic int rows_at(input int s);
    int n;
    n = N;
    for (int k = 0; k < s; k++) n = (n / 3) * 2 + (n % 3);
    return n;
  endfunction

  function automatic int levels_needed();
    int n;
    int s;
    n = N;
    s = 0;
    while (n > 2) begin
      n = (n / 3) * 2 + (n % 3);
      s++;
    end
    return s;
  endfunction

  localparam int NLVL = levels_needed();

  // Columns zero-extended to a common height so they can be transposed into rows.
  logic [N-1:0] w_col [0:NCOL-1];

  assign w_col[0]  = N'(src0);
  assign w_col[1]  = N'(src1);
  assign w_col[2]  = N'(src2);
  assign w_col[3]  = N'(src3);
  assign w_col[4]  = N'(src4);
  assign w_col[5]  = N'(src5);
  assign w_col[6]  = N'(src6);
  assign w_col[7]  = N'(src7);
  assign w_col[8]  = N'(src8);
  assign w_col[9]  = N'(src9);
  assign w_col[10] = N'(src10);
  assign w_col[11] = N'(src11);
  assign w_col[12] = N'(src12);
  assign w_col[13] = N'(src13);
  assign w_col[14] = N'(src14);
  assign w_col[15] = N'(src15);
  assign w_col[16] = N'(src16);
  assign w_col[17] = N'(src17);
  assign w_col[18] = N'(src18);
  assign w_col[19] = N'(src19);
  assign w_col[20] = N'(src20);
  assign w_col[21] = N'(src21);
  assign w_col[22] = N'(src22);
  assign w_col[23] = N'(src23);
  assign w_col[24] = N'(src24);
  assign w_col[25] = N'(src25);
  assign w_col[26] = N'(src26);
  assign w_col[27] = N'(src27);
  assign w_col[28] = N'(src28);
  assign w_col[29] = N'(src29);
  assign w_col[30] = N'(src30);
  assign w_col[31] = N'(src31);
  assign w_col[32] = N'(src32);
  assign w_col[33] = N'(src33);
  assign w_col[34] = N'(src34);
  assign w_col[35] = N'(src35);
  assign w_col[36] = N'(src36);
  assign w_col[37] = N'(src37);
  assign w_col[38] = N'(src38);

  // Level 0 holds the matrix as N rows; level s holds rows_at(s) carry-save rows.
  // Every full adder keeps its sum in column c and pushes its carry to column c+1,
  // which at row granularity is a one-bit left shift of the majority vector.
  for (genvar s = 0; s <= NLVL; s++) begin : g_lvl
    localparam int NOUT = rows_at(s);
    logic [W-1:0] w_rows [0:NOUT-1];

    if (s == 0) begin : g_init
      for (genvar b = 0; b < N; b++) begin : g_row
        for (genvar c = 0; c < W; c++) begin : g_bit
          if (c < NCOL) begin : g_live
            assign w_rows[b][c] = w_col[c][b];
          end else begin : g_pad
            assign w_rows[b][c] = 1'b0;
          end
        end
      end
    end else begin : g_csa
      localparam int NIN = rows_at(s - 1);
      localparam int NGRP = NIN / 3;
      for (genvar k = 0; k < NGRP; k++) begin : g_fa
        assign w_rows[2*k] = g_lvl[s-1].w_rows[3*k]
                           ^ g_lvl[s-1].w_rows[3*k+1]
                           ^ g_lvl[s-1].w_rows[3*k+2];
        // The carry out of the top column is always 0: the full sum is < 2^W.
        assign w_rows[2*k+1] = {(g_lvl[s-1].w_rows[3*k][W-2:0]   & g_lvl[s-1].w_rows[3*k+1][W-2:0])
                              | (g_lvl[s-1].w_rows[3*k][W-2:0]   & g_lvl[s-1].w_rows[3*k+2][W-2:0])
                              | (g_lvl[s-1].w_rows[3*k+1][W-2:0] & g_lvl[s-1].w_rows[3*k+2][W-2:0]),
                                1'b0};
      end
      for (genvar r = 0; r < NIN % 3; r++) begin : g_pass
        assign w_rows[2*NGRP + r] = g_lvl[s-1].w_rows[3*NGRP + r];
      end
    end
  end

  logic [W-1:0] w_sum;
  logic [W-1:0] r_prod;

  assign w_sum = g_lvl[NLVL].w_rows[0] + g_lvl[NLVL].w_rows[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prod <= '0;
    else        r_prod <= w_sum;
  end

  assign dst0  = r_prod[0];
  assign dst1  = r_prod[1];
  assign dst2  = r_prod[2];
  assign dst3  = r_prod[3];
  assign dst4  = r_prod[4];
  assign dst5  = r_prod[5];
  assign dst6  = r_prod[6];
  assign dst7  = r_prod[7];
  assign dst8  = r_prod[8];
  assign dst9  = r_prod[9];
  assign dst10 = r_prod[10];
  assign dst11 = r_prod[11];
  assign dst12 = r_prod[12];
  assign dst13 = r_prod[13];
  assign dst14 = r_prod[14];
  assign dst15 = r_prod[15];
  assign dst16 = r_prod[16];
  assign dst17 = r_prod[17];
  assign dst18 = r_prod[18];
  assign dst19 = r_prod[19];
  assign dst20 = r_prod[20];
  assign dst21 = r_prod[21];
  assign dst22 = r_prod[22];
  assign dst23 = r_prod[23];
  assign dst24 = r_prod[24];
  assign dst25 = r_prod[25];
  assign dst26 = r_prod[26];
  assign dst27 = r_prod[27];
  assign dst28 = r_prod[28];
  assign dst29 = r_prod[29];
  assign dst30 = r_prod[30];
  assign dst31 = r_prod[31];
  assign dst32 = r_prod[32];
  assign dst33 = r_prod[33];
  assign dst34 = r_prod[34];
  assign dst35 = r_prod[35];
  assign dst36 = r_prod[36];
  assign dst37 = r_prod[37];
  assign dst38 = r_prod[38];
  assign dst39 = r_prod[39];

endmodule

// File: tb/tb_mul20_compressor.sv
// Purpose : self-checking bench for mul20_compressor against a popcount-weighted sum model.
// Latency : expects the product one rising edge after the columns are applied.
// Backpressure: none; stimulus is applied every cycle.
module tb_mul20_compressor;

  logic        clk;
  logic        rst_n;
  logic [19:0] col [0:38];
  wire  [39:0] dst;

  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mul20_compressor #(.N(20)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .src0  (col[0][0:0]),   .src1  (col[1][1:0]),   .src2  (col[2][2:0]),
    .src3  (col[3][3:0]),   .src4  (col[4][4:0]),   .src5  (col[5][5:0]),
    .src6  (col[6][6:0]),   .src7  (col[7][7:0]),   .src8  (col[8][8:0]),
    .src9  (col[9][9:0]),   .src10 (col[10][10:0]), .src11 (col[11][11:0]),
    .src12 (col[12][12:0]), .src13 (col[13][13:0]), .src14 (col[14][14:0]),
    .src15 (col[15][15:0]), .src16 (col[16][16:0]), .src17 (col[17][17:0]),
    .src18 (col[18][18:0]), .src19 (col[19][19:0]), .src20 (col[20][18:0]),
    .src21 (col[21][17:0]), .src22 (col[22][16:0]), .src23 (col[23][15:0]),
    .src24 (col[24][14:0]), .src25 (col[25][13:0]), .src26 (col[26][12:0]),
    .src27 (col[27][11:0]), .src28 (col[28][10:0]), .src29 (col[29][9:0]),
    .src30 (col[30][8:0]),  .src31 (col[31][7:0]),  .src32 (col[32][6:0]),
    .src33 (col[33][5:0]),  .src34 (col[34][4:0]),  .src35 (col[35][3:0]),
    .src36 (col[36][2:0]),  .src37 (col[37][1:0]),  .src38 (col[38][0:0]),
    .dst0  (dst[0]),  .dst1  (dst[1]),  .dst2  (dst[2]),  .dst3  (dst[3]),
    .dst4  (dst[4]),  .dst5  (dst[5]),  .dst6  (dst[6]),  .dst7  (dst[7]),
    .dst8  (dst[8]),  .dst9  (dst[9]),  .dst10 (dst[10]), .dst11 (dst[11]),
    .dst12 (dst[12]), .dst13 (dst[13]), .dst14 (dst[14]), .dst15 (dst[15]),
    .dst16 (dst[16]), .dst17 (dst[17]), .dst18 (dst[18]), .dst19 (dst[19]),
    .dst20 (dst[20]), .dst21 (dst[21]), .dst22 (dst[22]), .dst23 (dst[23]),
    .dst24 (dst[24]), .dst25 (dst[25]), .dst26 (dst[26]), .dst27 (dst[27]),
    .dst28 (dst[28]), .dst29 (dst[29]), .dst30 (dst[30]), .dst31 (dst[31]),
    .dst32 (dst[32]), .dst33 (dst[33]), .dst34 (dst[34]), .dst35 (dst[35]),
    .dst36 (dst[36]), .dst37 (dst[37]), .dst38 (dst[38]), .dst39 (dst[39])
  );

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int col_height(input int i);
    return (i < 20) ? i + 1 : 39 - i;
  endfunction

  // Each live bit of column I contributes 2^I; bits above the column height do not exist.
  function automatic logic [39:0] ref_sum();
    logic [63:0] s;
    logic [19:0] m;
    s = 64'd0;
    for (int i = 0; i < 39; i++) begin
      m = 20'((64'd1 << col_height(i)) - 64'd1);
      s += 64'($countones(col[i] & m)) << i;
    end
    return s[39:0];
  endfunction

  task automatic clear_cols();
    for (int i = 0; i < 39; i++) col[i] = '0;
  endtask

  task automatic rand_cols(input int mode);
    for (int i = 0; i < 39; i++) begin
      case (mode)
        0:       col[i] = 20'($urandom());
        1:       col[i] = 20'($urandom() & $urandom() & $urandom());
        2:       col[i] = 20'($urandom() | $urandom() | $urandom());
        default: col[i] = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'h0;
      endcase
    end
  endtask

  // Load columns with the AND partial products a[i]&b[j], grouped by i+j.
  task automatic load_pp(input logic [19:0] a, input logic [19:0] b);
    clear_cols();
    for (int i = 0; i < 20; i++)
      for (int j = 0; j < 20; j++) begin
        int c;
        int k;
        c = i + j;
        k = (c < 20) ? i : i - (c - 19);
        col[c][k] = a[i] & b[j];
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [39:0] exp;
    logic [63:0] prod;
    n_tests = 0;
    n_fail  = 0;

    // Reset held with random columns: output must be zero, even across edges.
    rst_n = 1'b0;
    rand_cols(0);
    #2;
    chk("reset_async", dst, 40'h0);
    step();
    rand_cols(2);
    step();
    chk("reset_held", dst, 40'h0);

    @(negedge clk);
    rst_n = 1'b1;
    clear_cols();
    step();
    chk("zero_cols", dst, 40'h0);

    // Every bit set: the full (2^20-1)^2 product.
    for (int i = 0; i < 39; i++) col[i] = 20'hFFFFF;
    step();
    chk("all_ones", dst, 40'hFF_FFE0_0001);

    clear_cols();
    col[19][7] = 1'b1;
    step();
    chk("single_c19", dst, 40'h1 << 19);

    clear_cols();
    col[38][0] = 1'b1;
    step();
    chk("single_c38", dst, 40'h1 << 38);

    clear_cols();
    col[19] = 20'hFFFFF;
    step();
    chk("full_c19", dst, (40'h1 << 21) | (40'h1 << 23));

    // Back-to-back multiplies, one result per edge.
    load_pp(20'd12345, 20'd67890);
    step();
    chk("pp_12345x67890", dst, 40'd838102050);
    load_pp(20'hFFFFF, 20'hFFFFF);
    step();
    chk("pp_max", dst, 40'hFF_FFE0_0001);

    for (int t = 0; t < 40; t++) begin
      logic [19:0] a;
      logic [19:0] b;
      a = 20'($urandom());
      b = 20'($urandom());
      load_pp(a, b);
      prod = 64'(a) * 64'(b);
      step();
      chk("pp_rand", dst, prod[39:0]);
    end

    // Asynchronous reset between edges while the output is nonzero.
    rand_cols(2);
    exp = ref_sum();
    step();
    chk("pre_midreset", dst, exp);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_async", dst, 40'h0);
    step();
    chk("midreset_held", dst, 40'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rand_cols(0);
    exp = ref_sum();
    step();
    chk("post_reset_first", dst, exp);

    // Random sweep against the popcount-weighted model.
    for (int t = 0; t < 10000; t++) begin
      rand_cols(t % 4);
      exp = ref_sum();
      step();
      chk("sweep", dst, exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
